trigger_gen: RTL and testbench
==============================

# trigger_gen

Initiator side of the trigger/sample-enable handshake. On `start` it emits a burst of `SP_NUM` fixed-width trigger pulses toward a sampling controller, spaced `PERIOD` cycles apart. Each pulse must be acknowledged by that controller's `sp_en` before the next pulse is issued. Missing acknowledgements are reported via timeout. The block sits upstream of the sampler and drives its `trigger` input, typically at 200 MHz.

## Interface
- `PULSE_W`, default 4: trigger high time in cycles, range 1..PERIOD-1.
- `PERIOD`, default 1000: cycles between consecutive trigger rising edges (5 us at 200 MHz).
- `SP_NUM`, default 6: triggers per burst, range 1..255.
- `TIMEOUT`, default 4096: cycles from a trigger rise to declaring a missing ack; must be greater than PERIOD.
- `CNT_W`, default 16: period/timeout counter width; PERIOD and TIMEOUT must be less than 2**CNT_W.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `abort`  in  1  terminate the burst; honoured in any state.
- `sp_en`  in  1  acknowledge from the sampler; high one or more cycles per trigger.
- `trigger`  out  1  registered trigger pulse.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `timeout_err`  out  1  one-cycle pulse when a burst is ended by a missing ack.
- `sp_seen`  out  8  number of `sp_en`-high cycles counted in the current or last burst.

## Operation
- States: IDLE, PULSE, HOLD.
- Internal counters:
  - `pc` (CNT_W): cycles since the latest trigger rise; saturates.
  - `trig_cnt` (8 bit): triggers issued in this burst.
  - `ack` flag: set by any `sp_en` cycle since the latest trigger rise.
- IDLE:
  - Outputs `trigger`, `busy` are 0.
  - On `start` (with no `abort`): go to PULSE; clear `pc`, `ack`, `sp_seen`; set `trig_cnt` to 1.
- PULSE:
  - `trigger` is 1; `pc` increments.
  - After PULSE_W cycles (`pc` = PULSE_W-1), go to HOLD.
- HOLD:
  - `trigger` is 0; `pc` increments.
  - If `ack` is set and `trig_cnt` = SP_NUM: pulse `done`, go to IDLE.
  - Else if `ack` is set and `pc` ≥ PERIOD-1: go to PULSE; clear `pc` and `ack`; increment `trig_cnt`.
  - Else if `pc` = TIMEOUT-1 and `ack` is clear: pulse `timeout_err`, go to IDLE.
- Ack tracking:
  - `sp_en` is observed in PULSE and HOLD; an ack arriving during the pulse is valid.
  - Every `sp_en`-high cycle while `busy` increments `sp_seen`, saturating at 255.
  - Extra `sp_en` cycles do not re-arm `ack`.
  - `sp_en` is ignored in IDLE.
- `abort` in any state: next cycle is IDLE with `trigger` at 0. No `done` or `timeout_err` is issued; `sp_seen` is held.
- `abort` has priority over `start`, `done` and `timeout_err` in the same cycle.
- `start` while `busy` is ignored.
- `sp_seen` holds its value after `done` or timeout until the next accepted `start`.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Start latency: `start` sampled at edge k gives `trigger` = 1 for cycles k+1 .. k+PULSE_W; `busy` rises at k+1.
- Trigger rises are exactly PERIOD cycles apart when each ack arrives by `pc` = PERIOD-2.
- Late ack: if the ack is first sampled at `pc` = n ≥ PERIOD-1, the next trigger rises one cycle after that sample.
- `done` is high the cycle after the last trigger's ack is registered; `busy` falls in the same cycle.
- `timeout_err` is coincident with the fall of `busy`.
- `sp_en` is used as a synchronous, same-clock input with no synchroniser.

## Structure
- Shared package `trigger_pkg`:
  - State enum with IDLE/PULSE/HOLD.
  - Default localparams for PERIOD (1000) and SP_NUM (6), shared with the sampler.
- Single module; no sub-module warranted.

## Test plan
- Reset: assert `rst` mid-burst → all outputs 0 immediately; no `done` after release.
- Nominal burst: responder raises `sp_en` for one cycle, two cycles after each trigger rise; SP_NUM=6, PERIOD=1000, PULSE_W=4 → 6 pulses, each 4 cycles wide, rises 1000 cycles apart; `done` one cycle after the 6th ack; `sp_seen`=6.
- Late ack: ack for trigger 3 delayed to `pc`=1200 → trigger 4 rises one cycle after that ack sample; other spacings remain 1000.
- Timeout: responder silent after trigger 2 → `timeout_err` at `pc`=4095; `busy` falls; `sp_seen`=1.
- Abort during PULSE of trigger 2 → `trigger` low the next cycle; no `done`; a subsequent `start` begins a fresh burst with `sp_seen` cleared.
- Edge cases:
  - `start` while busy → ignored.
  - `start` and `abort` in the same IDLE cycle → stays IDLE.
  - `sp_en` held 3 cycles per trigger → `sp_seen`=18, spacing unchanged.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger/sample-enable handshake.
// Holds the initiator FSM state encoding and the default burst geometry,
// which the sampling controller also uses so both sides agree on it.
package trigger_pkg;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Default spacing between trigger rises, in clock cycles (5 us at 200 MHz).
  localparam int unsigned DefPeriod = 1000;
  // Default number of triggers per burst.
  localparam int unsigned DefSpNum  = 6;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trigger_gen.sv
// trigger_gen: initiator side of the trigger/sample-enable handshake.
//
// On start_i it issues a burst of SP_NUM trigger pulses, each PULSE_W cycles
// wide, with rising edges PERIOD cycles apart. Every pulse must be acknowledged
// by sp_en_i before the next one is issued; a late ack delays the next rise,
// and no ack within TIMEOUT cycles of a rise ends the burst with timeout_err_o.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   start_i        begin a burst (only looked at while idle)
//   abort_i        end the burst immediately, in any state
//   sp_en_i        acknowledge from the sampler (same clock domain)
//   trigger_o      registered trigger pulse
//   busy_o         high while a burst is in progress
//   done_o         one-cycle pulse on normal burst completion
//   timeout_err_o  one-cycle pulse when a missing ack ends the burst
//   sp_seen_o      sp_en_i-high cycles counted in the current/last burst
module trigger_gen
  import trigger_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned PERIOD  = DefPeriod,
  parameter int unsigned SP_NUM  = DefSpNum,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       sp_en_i,
  output logic       trigger_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_err_o,
  output logic [7:0] sp_seen_o
);

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] PeriodLast  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PcMax       = {CNT_W{1'b1}};
  localparam logic [7:0]       SpNumLast   = 8'(SP_NUM);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pc_q, pc_d;           // cycles since latest trigger rise
  logic [7:0]       trig_cnt_q, trig_cnt_d;
  logic             ack_q, ack_d;         // ack seen since latest trigger rise
  logic [7:0]       sp_seen_q, sp_seen_d;
  logic             trigger_q, trigger_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] pc_inc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    trig_cnt_d = trig_cnt_q;
    ack_d      = ack_q;
    sp_seen_d  = sp_seen_q;
    trigger_d  = trigger_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    pc_inc     = (pc_q == PcMax) ? pc_q : pc_q + CNT_W'(1);

    if (abort_i) begin
      // Abort wins over everything; sp_seen is frozen and no status pulse fires.
      state_d   = StIdle;
      trigger_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          trigger_d = 1'b0;
          busy_d    = 1'b0;
          if (start_i) begin
            state_d    = StPulse;
            pc_d       = '0;
            ack_d      = 1'b0;
            sp_seen_d  = '0;
            trig_cnt_d = 8'd1;
            trigger_d  = 1'b1;
            busy_d     = 1'b1;
          end
        end

        StPulse: begin
          pc_d = pc_inc;
          // An ack arriving while the pulse is still high is valid.
          if (sp_en_i) begin
            ack_d     = 1'b1;
            sp_seen_d = sat_inc8(sp_seen_q);
          end
          // The pulse always runs its full width, even if already acked.
          if (pc_q == PulseLast) begin
            state_d   = StHold;
            trigger_d = 1'b0;
          end
        end

        StHold: begin
          pc_d = pc_inc;
          if (sp_en_i) begin
            ack_d     = 1'b1;
            sp_seen_d = sat_inc8(sp_seen_q);
          end
          if (ack_q && (trig_cnt_q == SpNumLast)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (ack_q && (pc_q >= PeriodLast)) begin
            // Either exactly on the period or immediately after a late ack.
            state_d    = StPulse;
            pc_d       = '0;
            ack_d      = 1'b0;
            trig_cnt_d = trig_cnt_q + 8'd1;
            trigger_d  = 1'b1;
          end else if (!ack_q && (pc_q == TimeoutLast)) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end

        default: begin
          state_d   = StIdle;
          trigger_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      trig_cnt_q <= '0;
      ack_q      <= 1'b0;
      sp_seen_q  <= '0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      trig_cnt_q <= trig_cnt_d;
      ack_q      <= ack_d;
      sp_seen_q  <= sp_seen_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign trigger_o     = trigger_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = timeout_q;
  assign sp_seen_o     = sp_seen_q;

endmodule

// File: tb/tb_trigger_gen.sv
// Testbench for trigger_gen: expected trigger edges and status pulses are queued
// when each burst is launched; a monitor pops and compares them as they appear.
module tb_trigger_gen;

  localparam int PW  = 4;
  localparam int PER = 1000;
  localparam int NUM = 6;
  localparam int TO  = 4096;

  localparam int EvRise = 0;
  localparam int EvFall = 1;
  localparam int EvDone = 2;
  localparam int EvTo   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stim_sp = 1'b0;
  logic       resp_sp = 1'b0;
  logic       sp_en;
  logic       trigger, busy, done, timeout_err;
  logic [7:0] sp_seen;

  assign sp_en = resp_sp | stim_sp;

  trigger_gen #(
    .PULSE_W(PW),
    .PERIOD (PER),
    .SP_NUM (NUM),
    .TIMEOUT(TO),
    .CNT_W  (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .sp_en_i      (sp_en),
    .trigger_o    (trigger),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_err_o(timeout_err),
    .sp_seen_o    (sp_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    int seen;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- responder: acks each trigger after a programmable delay
  int   resp_idx = 0;
  int   resp_pc = 0;
  int   ack_len = 1;
  int   late_idx = 0;
  int   late_pc = 0;
  int   last_ack = NUM;
  logic resp_prev = 1'b0;

  always @(negedge clk) begin
    int dly;
    if (rst) begin
      resp_prev = 1'b0;
      resp_sp   = 1'b0;
    end else begin
      if (trigger && !resp_prev) begin
        resp_idx++;
        resp_pc = 0;
      end else begin
        resp_pc++;
      end
      resp_prev = trigger;
      dly = (resp_idx == late_idx) ? late_pc : 2;
      resp_sp = (resp_idx >= 1) && (resp_idx <= last_ack) &&
                (resp_pc >= dly) && (resp_pc < dly + ack_len);
    end
  end

  // ---------------- monitor: pops the scoreboard on every observable event
  logic mon_prev = 1'b0;

  function automatic void got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.at);
      if (kind == EvDone || kind == EvTo) begin
        chk("ev_sp_seen", int'(sp_seen), e.seen);
        chk("ev_busy_low", int'(busy), 0);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      if (trigger && !mon_prev) got(EvRise);
      if (!trigger && mon_prev) got(EvFall);
      if (done) got(EvDone);
      if (timeout_err) got(EvTo);
      mon_prev = trigger;
    end
  end

  // ---------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int k, input int t, input int s);
    exp_q.push_back('{kind: k, at: t, seen: s});
  endtask

  task automatic push_pulse(input int r);
    push(EvRise, r, 0);
    push(EvFall, r + PW, 0);
  endtask

  task automatic setup_resp(input int len, input int lidx, input int lpc, input int last);
    ack_len  = len;
    late_idx = lidx;
    late_pc  = lpc;
    last_ack = last;
    resp_idx = 0;
    tick(1);
  endtask

  task automatic start_burst();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_nominal(input int r, input int seen);
    for (int i = 0; i < NUM; i++) push_pulse(r + i * PER);
    push(EvDone, r + (NUM - 1) * PER + PW + 1, seen);
  endtask

  // ---------------- directed scenarios
  initial begin
    int c;
    int r;

    // Reset state.
    rst = 1'b1;
    tick(2);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    chk("rst_sp_seen", int'(sp_seen), 0);
    rst = 1'b0;
    tick(2);

    // start and abort together while idle: stays idle.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", int'(busy), 0);
    chk("sa_trigger", int'(trigger), 0);
    tick(5);
    chk("sa_busy_later", int'(busy), 0);

    // Nominal burst, with a stray start while busy.
    setup_resp(1, 0, 0, NUM);
    c = cyc;
    r = c + 1;
    push_nominal(r, NUM);
    start_burst();
    chk("nom_busy", int'(busy), 1);
    chk("nom_sp_seen_clr", int'(sp_seen), 0);
    wait_until(c + 1500);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    drain("nom_drain", 8000);

    // sp_en while idle is ignored and sp_seen holds.
    stim_sp = 1'b1;
    tick(3);
    stim_sp = 1'b0;
    tick(1);
    chk("idle_sp_seen", int'(sp_seen), NUM);
    chk("idle_busy", int'(busy), 0);

    // Late ack on trigger 3 at pc=1200.
    setup_resp(1, 3, 1200, NUM);
    c = cyc;
    r = c + 1;
    push_pulse(r);
    push_pulse(r + PER);
    push_pulse(r + 2 * PER);
    r = r + 2 * PER + 1202;
    push_pulse(r);
    push_pulse(r + PER);
    push_pulse(r + 2 * PER);
    push(EvDone, r + 2 * PER + PW + 1, NUM);
    start_burst();
    drain("late_drain", 8000);

    // Silent after trigger 1 ack: timeout on trigger 2.
    setup_resp(1, 0, 0, 1);
    c = cyc;
    r = c + 1;
    push_pulse(r);
    push_pulse(r + PER);
    push(EvTo, r + PER + TO, 1);
    start_burst();
    drain("to_drain", 8000);
    tick(2);
    chk("to_busy", int'(busy), 0);

    // Abort during the pulse of trigger 2.
    setup_resp(1, 0, 0, NUM);
    c = cyc;
    r = c + 1;
    push_pulse(r);
    push(EvRise, r + PER, 0);
    push(EvFall, r + PER + 2, 0);
    start_burst();
    wait_until(r + PER + 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_trigger", int'(trigger), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_sp_seen", int'(sp_seen), 1);
    tick(PER + 50);
    drain("ab_drain", 10);
    chk("ab_sp_seen_held", int'(sp_seen), 1);

    // Fresh burst after abort, sampler holding sp_en 3 cycles per trigger.
    setup_resp(3, 0, 0, NUM);
    c = cyc;
    r = c + 1;
    push_nominal(r, 3 * NUM);
    start_burst();
    chk("fresh_sp_seen", int'(sp_seen), 0);
    chk("fresh_busy", int'(busy), 1);
    drain("held_drain", 8000);

    // Asynchronous reset in the middle of a burst.
    setup_resp(1, 0, 0, NUM);
    c = cyc;
    r = c + 1;
    push_pulse(r);
    push_pulse(r + PER);
    start_burst();
    wait_until(r + PER + 500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_trigger", int'(trigger), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_timeout", int'(timeout_err), 0);
    chk("mid_rst_sp_seen", int'(sp_seen), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(PER + 200);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_trigger", int'(trigger), 0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
